// File: rtl/wbk_pkg.sv
// Shared types for the write-back port arbiter: the buffered write request and
// the hard-wired zero register index.
package wbk_pkg;

   typedef struct packed {
      logic        wb;
      logic        kill;
      logic [5:0]  dest;
      logic [31:0] data;
   } wb_req_t;

   localparam logic [5:0] REG_ZERO = 6'd0;

   // A write reaches the register file only when enabled, not squashed and not to r0.
   function automatic logic req_writes(input wb_req_t req);
      return req.wb && !req.kill && (req.dest != REG_ZERO);
   endfunction

endpackage

// File: rtl/wbk_wport_arbiter_if.sv
// Pipeline / long-latency unit / register-file write port bundle.
// WBK_ARB_PERF_EN adds the two performance counter outputs.
interface wbk_wport_arbiter_if;

   logic        PIPE_VALID;
   logic        PIPE_WB;
   logic [5:0]  PIPE_DEST;
   logic [31:0] PIPE_DATA;
   logic        PIPE_POP;
   logic        LU_VALID;
   logic [5:0]  LU_DEST;
   logic [31:0] LU_DATA;
   logic        LU_READY;
   logic        WB_SW;
   logic [5:0]  DEST_SW;
   logic [31:0] DATA_SW;
   logic        LU_PENDING;
`ifdef WBK_ARB_PERF_EN
   logic [31:0] PERF_LU_FORCED;
   logic [31:0] PERF_PIPE_STALL;
`endif

   modport slave (
      input  PIPE_VALID, PIPE_WB, PIPE_DEST, PIPE_DATA,
      input  LU_VALID, LU_DEST, LU_DATA,
      output PIPE_POP, LU_READY, WB_SW, DEST_SW, DATA_SW, LU_PENDING
`ifdef WBK_ARB_PERF_EN
      , output PERF_LU_FORCED, PERF_PIPE_STALL
`endif
   );

   modport master (
      output PIPE_VALID, PIPE_WB, PIPE_DEST, PIPE_DATA,
      output LU_VALID, LU_DEST, LU_DATA,
      input  PIPE_POP, LU_READY, WB_SW, DEST_SW, DATA_SW, LU_PENDING
`ifdef WBK_ARB_PERF_EN
      , input PERF_LU_FORCED, PERF_PIPE_STALL
`endif
   );

endinterface

// File: rtl/wbk_lu_fifo.sv
// Long-latency result FIFO with a per-entry kill-by-destination port used to
// squash buffered results overtaken by a younger pipeline write.
import wbk_pkg::*;

module wbk_lu_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       push,
   input  wb_req_t    push_req,
   input  logic       pop,
   input  logic       kill_en,
   input  logic [5:0] kill_dest,
   output wb_req_t    head,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   wb_req_t          mem_reg [DEPTH];
   logic [DEPTH-1:0] vld_reg;
   logic [DEPTH-1:0] kill_hit;
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    rd_idx;
   logic             push_ok;
   logic             pop_ok;
   wb_req_t          push_next;

   assign wr_idx  = wr_ptr_reg[AW-1:0];
   assign rd_idx  = rd_ptr_reg[AW-1:0];
   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_idx == rd_idx);
   assign head    = mem_reg[rd_idx];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_kill
         assign kill_hit[gi] = kill_en && vld_reg[gi] && (mem_reg[gi].dest == kill_dest);
      end
   endgenerate

   // A result arriving alongside a same-dest pipeline write is already stale.
   always_comb begin
      push_next      = push_req;
      push_next.kill = push_req.kill || (kill_en && (push_req.dest == kill_dest));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         vld_reg    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (kill_hit[i]) begin
               mem_reg[i].kill <= 1'b1;
            end
            if (pop_ok && (rd_idx == AW'(i))) begin
               vld_reg[i] <= 1'b0;
            end
            if (push_ok && (wr_idx == AW'(i))) begin
               mem_reg[i] <= push_next;
               vld_reg[i] <= 1'b1;
            end
         end
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/wbk_wport_arbiter.sv
// Register-file write port arbiter: pipeline has priority, buffered LU results
// drain when idle or when the starvation limit is hit. WBK_ARB_PERF_EN adds perf counters.
import wbk_pkg::*;

module wbk_wport_arbiter #(
   parameter int LU_DEPTH   = 4,
   parameter int STARVE_MAX = 8
) (
   input logic             clk,
   input logic             reset_n,
   wbk_wport_arbiter_if.slave bus
);

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   wb_req_t     head;
   wb_req_t     push_req;
   logic        full;
   logic        empty;
   logic        forced;
   logic        pipe_grant;
   logic        lu_grant;
   logic        lu_push;
   logic        kill_en;
   logic [7:0]  starve_cnt_reg;
   logic        wb_sw_reg;
   logic [5:0]  dest_sw_reg;
   logic [31:0] data_sw_reg;

   assign forced     = !empty && (starve_cnt_reg == STARVE_LIM);
   assign pipe_grant = bus.PIPE_VALID && !forced;
   assign lu_grant   = !empty && (forced || !bus.PIPE_VALID);
   assign lu_push    = bus.LU_VALID && !full;
   assign kill_en    = pipe_grant && bus.PIPE_WB;

   always_comb begin
      push_req      = '0;
      push_req.wb   = 1'b1;
      push_req.dest = bus.LU_DEST;
      push_req.data = bus.LU_DATA;
   end

   wbk_lu_fifo #(
      .DEPTH(LU_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (lu_push),
      .push_req (push_req),
      .pop      (lu_grant),
      .kill_en  (kill_en),
      .kill_dest(bus.PIPE_DEST),
      .head     (head),
      .full     (full),
      .empty    (empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt_reg <= '0;
         wb_sw_reg      <= 1'b0;
         dest_sw_reg    <= '0;
         data_sw_reg    <= '0;
      end else begin
         if (empty || lu_grant) begin
            starve_cnt_reg <= '0;
         end else if (pipe_grant && (starve_cnt_reg != STARVE_LIM)) begin
            starve_cnt_reg <= starve_cnt_reg + 8'd1;
         end

         // Killed LU entries still occupy the port for a cycle, just without writing.
         if (pipe_grant) begin
            wb_sw_reg   <= bus.PIPE_WB && (bus.PIPE_DEST != REG_ZERO);
            dest_sw_reg <= bus.PIPE_DEST;
            data_sw_reg <= bus.PIPE_DATA;
         end else if (lu_grant) begin
            wb_sw_reg   <= req_writes(head);
            dest_sw_reg <= head.dest;
            data_sw_reg <= head.data;
         end else begin
            wb_sw_reg   <= 1'b0;
         end
      end
   end

   assign bus.PIPE_POP   = pipe_grant;
   assign bus.LU_READY   = !full;
   assign bus.LU_PENDING = !empty;
   assign bus.WB_SW      = wb_sw_reg;
   assign bus.DEST_SW    = dest_sw_reg;
   assign bus.DATA_SW    = data_sw_reg;

`ifdef WBK_ARB_PERF_EN
   logic [31:0] perf_forced_reg;
   logic [31:0] perf_stall_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_forced_reg <= '0;
         perf_stall_reg  <= '0;
      end else begin
         if (forced) begin
            perf_forced_reg <= perf_forced_reg + 32'd1;
         end
         if (bus.PIPE_VALID && !pipe_grant) begin
            perf_stall_reg <= perf_stall_reg + 32'd1;
         end
      end
   end

   assign bus.PERF_LU_FORCED  = perf_forced_reg;
   assign bus.PERF_PIPE_STALL = perf_stall_reg;
`endif

endmodule
